// File: rtl/mdu_pipe_pkg.sv
// mdu_pkg: shared definitions for the parametrised multiply/divide unit.
//   - MDU op codes (4-bit; codes 11..15 are unused and behave as NONE)
//   - state_t: control state of the unit (IDLE / BUSY)
//   - is_multicycle(): true for ops that occupy the busy counter
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_pipe_if.sv
// mdu_pipe_if: E-stage <-> MDU connection.
//   master (pipeline side): drives start/op/in1/in2/flush/md_use,
//                           receives busy/stall/hi/lo
//   slave  (MDU side):      the reverse
interface mdu_pipe_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             flush;
  logic             md_use;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, in1, in2, flush, md_use,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, in1, in2, flush, md_use,
    output busy, stall, hi, lo
  );

endinterface

// File: rtl/mdu_pipe_calc.sv
// mdu_calc: purely combinational MDU datapath.
//   op             : operation code (mdu_pkg constants)
//   in1, in2       : rs / rt operands
//   cur_hi, cur_lo : HI/LO at the start edge (accumulate base, div-by-zero hold)
//   result         : {new_hi, new_lo}, 2*WIDTH bits
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [WIDTH-1:0]   cur_hi,
  input  logic [WIDTH-1:0]   cur_lo,
  output logic [2*WIDTH-1:0] result
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [W2-1:0]           acc;
  logic signed [W2-1:0]    a_ext;
  logic signed [W2-1:0]    b_ext;
  logic [W2-1:0]           prod_s;
  logic [W2-1:0]           prod_u;
  logic                    div_zero;
  logic                    div_ovf;
  logic [WIDTH-1:0]        dvs_s;
  logic [WIDTH-1:0]        dvs_u;
  logic [WIDTH-1:0]        q_s;
  logic [WIDTH-1:0]        r_s;
  logic [WIDTH-1:0]        q_u;
  logic [WIDTH-1:0]        r_u;

  always_comb begin
    acc    = {cur_hi, cur_lo};
    a_ext  = {{WIDTH{in1[WIDTH-1]}}, in1};
    b_ext  = {{WIDTH{in2[WIDTH-1]}}, in2};
    prod_s = a_ext * b_ext;
    prod_u = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};

    // Divisor 0 and MIN / -1 are steered to a divide by one so the divider
    // never sees an undefined case; MIN / 1 yields exactly lo=MIN, hi=0.
    div_zero = (in2 == '0);
    div_ovf  = (in1 == MIN) && (in2 == '1);
    dvs_s    = (div_zero || div_ovf) ? ONE : in2;
    dvs_u    = div_zero ? ONE : in2;
    q_s      = $signed(in1) / $signed(dvs_s);
    r_s      = $signed(in1) % $signed(dvs_s);
    q_u      = in1 / dvs_u;
    r_u      = in1 % dvs_u;

    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_MADD:  result = acc + prod_s;
      MDU_MADDU: result = acc + prod_u;
      MDU_MSUB:  result = acc - prod_s;
      MDU_MSUBU: result = acc - prod_u;
      MDU_DIV:   result = div_zero ? acc : {r_s, q_s};
      MDU_DIVU:  result = div_zero ? acc : {r_u, q_u};
      default:   result = acc;
    endcase
  end

endmodule

// File: rtl/mdu_pipe.sv
// mdu_pipe: multiply/divide unit for the E stage. Owns HI/LO, models the
// multi-cycle latency with a busy counter and raises the pipeline stall.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : mdu_pipe_if.slave
//             start/op/in1/in2 : E-stage operation request
//             flush            : abort in-flight op, suppress start
//             md_use           : D-stage instruction needs the MDU
//             busy/stall       : operation in flight / pipeline freeze
//             hi/lo            : HI and LO registers
module mdu_pipe #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  mdu_pipe_if.slave bus
);

  import mdu_pkg::*;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                busy_q;
  logic [WIDTH-1:0]    hi_q;
  logic [WIDTH-1:0]    lo_q;
  logic [WIDTH-1:0]    pend_hi;
  logic [WIDTH-1:0]    pend_lo;
  logic [2*WIDTH-1:0]  calc_result;
  logic                multi;
  logic                is_div;
  logic                accept;

  mdu_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .op     (bus.op),
    .in1    (bus.in1),
    .in2    (bus.in2),
    .cur_hi (hi_q),
    .cur_lo (lo_q),
    .result (calc_result)
  );

  always_comb begin
    multi  = is_multicycle(bus.op);
    is_div = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
    accept = bus.start && !bus.flush && (state == IDLE);
  end

  // The result is computed from the start-edge operands and parked in
  // pend_*; HI/LO only change on the completing edge, so a flush simply
  // drops the parked value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (multi) begin
              pend_hi <= calc_result[2*WIDTH-1:WIDTH];
              pend_lo <= calc_result[WIDTH-1:0];
              cnt     <= is_div ? DIV_LAT : MULT_LAT;
              busy_q  <= 1'b1;
              state   <= BUSY;
            end else if (bus.op == MDU_MTHI) begin
              hi_q <= bus.in1;
            end else if (bus.op == MDU_MTLO) begin
              lo_q <= bus.in1;
            end
          end
        end
        BUSY: begin
          if (bus.flush) begin
            cnt     <= '0;
            busy_q  <= 1'b0;
            pend_hi <= '0;
            pend_lo <= '0;
            state   <= IDLE;
          end else if (cnt == CNT_ONE) begin
            hi_q   <= pend_hi;
            lo_q   <= pend_lo;
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = bus.md_use & (busy_q | (bus.start & multi & ~bus.flush));

endmodule

// File: tb/tb_mdu_pipe.sv
// tb_mdu_pipe: drives a 32-bit MDU (5/10 cycles) and a 16-bit MDU (1/10
// cycles) with the same request stream and compares both against a
// transaction-level model every cycle, plus literal expectations.
module tb_mdu_pipe;

  import mdu_pkg::*;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        flush  = 1'b0;
  logic        md_use = 1'b0;
  logic [3:0]  op     = 4'd0;
  logic [31:0] in1    = 32'd0;
  logic [31:0] in2    = 32'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_pipe_if #(.WIDTH(32)) bus_a ();
  mdu_pipe_if #(.WIDTH(16)) bus_b ();

  assign bus_a.start  = start;
  assign bus_a.op     = op;
  assign bus_a.in1    = in1;
  assign bus_a.in2    = in2;
  assign bus_a.flush  = flush;
  assign bus_a.md_use = md_use;
  assign bus_b.start  = start;
  assign bus_b.op     = op;
  assign bus_b.in1    = in1[15:0];
  assign bus_b.in2    = in2[15:0];
  assign bus_b.flush  = flush;
  assign bus_b.md_use = md_use;

  mdu_pipe #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut_a (
    .clk(clk), .reset(rst_n), .bus(bus_a)
  );
  mdu_pipe #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(10)) dut_b (
    .clk(clk), .reset(rst_n), .bus(bus_b)
  );

  // ---------------- reference model ----------------
  function automatic int wid(input int u);
    return (u == 0) ? 32 : 16;
  endfunction

  function automatic bit multi_op(input logic [3:0] o);
    return (o inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10});
  endfunction

  function automatic int lat(input int u, input logic [3:0] o);
    if (o == 4'd3 || o == 4'd4) return 10;
    return (u == 0) ? 5 : 1;
  endfunction

  // {hi,lo} after op, computed with plain 64-bit arithmetic at width w.
  function automatic logic [63:0] model_op(input int w, input logic [3:0] o,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] h, input logic [31:0] l);
    longint unsigned m1, m2, ua, ub, acc, res, hv, lv;
    longint sa, sb, q, r;
    m1  = (64'd1 << w) - 64'd1;
    m2  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (2 * w)) - 64'd1;
    ua  = 64'(a) & m1;
    ub  = 64'(b) & m1;
    sa  = ua[w-1] ? $signed(ua) - $signed(64'd1 << w) : $signed(ua);
    sb  = ub[w-1] ? $signed(ub) - $signed(64'd1 << w) : $signed(ub);
    acc = ((64'(h) & m1) << w) | (64'(l) & m1);
    case (o)
      4'd1:    res = $unsigned(sa * sb);
      4'd2:    res = ua * ub;
      4'd7:    res = acc + $unsigned(sa * sb);
      4'd8:    res = acc + ua * ub;
      4'd9:    res = acc - $unsigned(sa * sb);
      4'd10:   res = acc - ua * ub;
      4'd3: begin
        if (ub == 0) res = acc;
        else begin
          q   = sa / sb;   // MIN/-1 gives +2^(w-1), which masks to MIN
          r   = sa % sb;
          res = (($unsigned(r) & m1) << w) | ($unsigned(q) & m1);
        end
      end
      4'd4:    res = (ub == 0) ? acc : (((ua % ub) << w) | (ua / ub));
      default: res = acc;
    endcase
    res = res & m2;
    hv  = (res >> w) & m1;
    lv  = res & m1;
    return {hv[31:0], lv[31:0]};
  endfunction

  logic [31:0] m_hi[2];
  logic [31:0] m_lo[2];
  logic [31:0] p_hi[2];
  logic [31:0] p_lo[2];
  bit          in_flight[2];
  int          done_at[2];
  int          cyc;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        m_hi[u] = '0; m_lo[u] = '0; p_hi[u] = '0; p_lo[u] = '0;
        in_flight[u] = 1'b0; done_at[u] = 0;
      end
      cyc = 0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (in_flight[u]) begin
          if (flush) in_flight[u] = 1'b0;
          else if (cyc == done_at[u]) begin
            m_hi[u] = p_hi[u];
            m_lo[u] = p_lo[u];
            in_flight[u] = 1'b0;
          end
        end else if (start && !flush) begin
          if (multi_op(op)) begin
            {p_hi[u], p_lo[u]} = model_op(wid(u), op, in1, in2, m_hi[u], m_lo[u]);
            done_at[u]   = cyc + lat(u, op);
            in_flight[u] = 1'b1;
          end else if (op == 4'd5) begin
            m_hi[u] = (u == 0) ? in1 : {16'd0, in1[15:0]};
          end else if (op == 4'd6) begin
            m_lo[u] = (u == 0) ? in1 : {16'd0, in1[15:0]};
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- checking ----------------
  task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int u, input logic b, input logic s,
                     input logic [31:0] h, input logic [31:0] l);
    logic es;
    es = md_use && (in_flight[u] || (start && multi_op(op) && !flush));
    ck($sformatf("u%0d busy", u),  32'(b), 32'(in_flight[u]));
    ck($sformatf("u%0d stall", u), 32'(s), 32'(es));
    ck($sformatf("u%0d hi", u),    h, m_hi[u]);
    ck($sformatf("u%0d lo", u),    l, m_lo[u]);
  endtask

  initial forever begin
    @(negedge clk);
    cmp(0, bus_a.busy, bus_a.stall, bus_a.hi, bus_a.lo);
    cmp(1, bus_b.busy, bus_b.stall, {16'd0, bus_b.hi}, {16'd0, bus_b.lo});
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op1(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; in1 = a; in2 = b;
    step();
    start = 1'b0; op = 4'd0;
  endtask

  // Counts busy cycles of the 32-bit unit (and of the 16-bit unit meanwhile).
  task automatic wait_done(output int na, output int nb);
    bit done;
    done = 1'b0; na = 0; nb = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus_b.busy) nb++;
      if (!bus_a.busy) begin done = 1'b1; break; end
      na++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done: busy still %b after 64 cycles, required 0", bus_a.busy);
    end
    step();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_8000;
      5:       return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int na, nb, sc;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb, sc;
    repeat (2) step();
    ck("reset busy", 32'(bus_a.busy), 32'd0);
    ck("reset hi", bus_a.hi, 32'd0);
    ck("reset lo", bus_a.lo, 32'd0);
    rst_n = 1'b1;
    step();

    op1(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    ck("mult hi pre", bus_a.hi, 32'd0);
    ck("mult lo pre", bus_a.lo, 32'd0);
    wait_done(na, nb);
    ck("mult busy cycles", 32'(na), 32'd5);
    ck("mult hi", bus_a.hi, 32'hFFFF_FFFF);
    ck("mult lo", bus_a.lo, 32'hFFFF_FFFA);

    op1(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(na, nb);
    ck("div busy cycles", 32'(na), 32'd10);
    ck("div lo", bus_a.lo, 32'hFFFF_FFFD);
    ck("div hi", bus_a.hi, 32'hFFFF_FFFF);

    op1(MDU_MTHI, 32'h11, 32'd0);
    op1(MDU_MTLO, 32'h22, 32'd0);
    ck("mthi", bus_a.hi, 32'h11);
    ck("mtlo", bus_a.lo, 32'h22);
    op1(MDU_DIVU, 32'h1234, 32'd0);
    wait_done(na, nb);
    ck("divu0 busy cycles", 32'(na), 32'd10);
    ck("divu0 hi", bus_a.hi, 32'h11);
    ck("divu0 lo", bus_a.lo, 32'h22);

    op1(MDU_MTHI, 32'hFFFF_FFFF, 32'd0);
    op1(MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
    op1(MDU_MADDU, 32'd1, 32'd1);
    wait_done(na, nb);
    ck("maddu hi", bus_a.hi, 32'd0);
    ck("maddu lo", bus_a.lo, 32'd0);

    // flush at busy cycle 3 with md_use held
    op1(MDU_MTHI, 32'hAA, 32'd0);
    op1(MDU_MTLO, 32'hBB, 32'd0);
    md_use = 1'b1;
    start = 1'b1; op = MDU_MULT; in1 = 32'd6; in2 = 32'd7;
    @(negedge clk);
    sc = int'(bus_a.stall);
    step();
    start = 1'b0; op = 4'd0;
    for (int j = 1; j <= 3; j++) begin
      if (j == 3) flush = 1'b1;
      @(negedge clk);
      sc += int'(bus_a.stall);
      step();
    end
    flush = 1'b0;
    @(negedge clk);
    ck("flush stall cycles", 32'(sc), 32'd4);
    ck("flush busy after", 32'(bus_a.busy), 32'd0);
    ck("flush stall after", 32'(bus_a.stall), 32'd0);
    ck("flush hi", bus_a.hi, 32'hAA);
    ck("flush lo", bus_a.lo, 32'hBB);
    step();
    md_use = 1'b0;

    start = 1'b1; op = MDU_MULT; in1 = 32'd3; in2 = 32'd3; flush = 1'b1;
    step();
    start = 1'b0; op = 4'd0;
    ck("start+flush busy", 32'(bus_a.busy), 32'd0);
    start = 1'b1; op = MDU_MTHI; in1 = 32'h55;
    step();
    start = 1'b0; op = 4'd0; flush = 1'b0;
    ck("mthi+flush hi", bus_a.hi, 32'hAA);

    op1(MDU_MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
    wait_done(na, nb);
    ck("w16 multu busy cycles", 32'(nb), 32'd1);
    ck("w16 multu hi", {16'd0, bus_b.hi}, 32'h0000_FFFE);
    ck("w16 multu lo", {16'd0, bus_b.lo}, 32'h0000_0001);
    ck("w32 multu hi", bus_a.hi, 32'd0);
    ck("w32 multu lo", bus_a.lo, 32'hFFFE_0001);

    // asynchronous reset in the middle of a divide
    op1(MDU_MTHI, 32'h77, 32'd0);
    op1(MDU_DIV, 32'd100, 32'd7);
    step();
    ck("div in flight", 32'(bus_a.busy), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    ck("async rst busy", 32'(bus_a.busy), 32'd0);
    ck("async rst hi", bus_a.hi, 32'd0);
    ck("async rst lo", bus_a.lo, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 1) == 1);
      op     = 4'($urandom_range(0, 15));
      in1    = pick();
      in2    = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      flush  = ($urandom_range(0, 15) == 0);
      md_use = ($urandom_range(0, 1) == 1);
      step();
    end
    start = 1'b0; flush = 1'b0; md_use = 1'b0; op = 4'd0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
